// File: rtl/verifier_pkg.sv
// Shared types and default golden values for the signature verifier.
// Field layout of the packed signature word is fixed here for every consumer.
package verifier_pkg;

  localparam int unsigned SIG_W   = 32;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned N_FIELD = 4;

  localparam logic [FIELD_W-1:0] DEF_EXP_REGION = 8'h0A;
  localparam logic [FIELD_W-1:0] DEF_EXP_AUTH   = 8'h01;
  localparam logic [FIELD_W-1:0] DEF_EXP_EXPIRY = 8'h10;
  localparam logic [FIELD_W-1:0] DEF_EXP_SIG_ID = 8'hF3;

  // Member order matches the bit map: region is the most significant byte.
  typedef struct packed {
    logic [FIELD_W-1:0] region;
    logic [FIELD_W-1:0] auth;
    logic [FIELD_W-1:0] expiry;
    logic [FIELD_W-1:0] sig_id;
  } sig_word_t;

endpackage : verifier_pkg

// File: rtl/sig_field_cmp.sv
// Exact-equality comparator for one 8-bit signature field.
// The golden value is a build-time parameter; output is purely combinational.
module sig_field_cmp
  import verifier_pkg::*;
#(
  parameter logic [FIELD_W-1:0] EXP = '0
) (
  input  logic [FIELD_W-1:0] i_field,
  output logic               o_eq
);

  always_comb begin
    o_eq = (i_field == EXP);
  end

endmodule : sig_field_cmp

// File: rtl/verifier_top.sv
// Signature verifier: registered all-fields-equal flag, one cycle of latency.
// Define VERIFIER_MISMATCH_FLAGS_EN to add the registered per-field mismatch[3:0] output.
module verifier_top
  import verifier_pkg::*;
#(
  parameter logic [FIELD_W-1:0] EXP_REGION = DEF_EXP_REGION,
  parameter logic [FIELD_W-1:0] EXP_AUTH   = DEF_EXP_AUTH,
  parameter logic [FIELD_W-1:0] EXP_EXPIRY = DEF_EXP_EXPIRY,
  parameter logic [FIELD_W-1:0] EXP_SIG_ID = DEF_EXP_SIG_ID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIG_W-1:0] signature_in,
  output logic             match
`ifdef VERIFIER_MISMATCH_FLAGS_EN
  ,
  output logic [N_FIELD-1:0] mismatch
`endif
);

  sig_word_t          w_sig;
  logic [N_FIELD-1:0] w_eq;
  logic               w_match;
  logic               r_match;

  assign w_sig = sig_word_t'(signature_in);

  // w_eq bit order mirrors mismatch: [3]=region .. [0]=sig_id.
  sig_field_cmp #(.EXP(EXP_REGION)) u_cmp_region (
    .i_field (w_sig.region),
    .o_eq    (w_eq[3])
  );

  sig_field_cmp #(.EXP(EXP_AUTH)) u_cmp_auth (
    .i_field (w_sig.auth),
    .o_eq    (w_eq[2])
  );

  sig_field_cmp #(.EXP(EXP_EXPIRY)) u_cmp_expiry (
    .i_field (w_sig.expiry),
    .o_eq    (w_eq[1])
  );

  sig_field_cmp #(.EXP(EXP_SIG_ID)) u_cmp_sig_id (
    .i_field (w_sig.sig_id),
    .o_eq    (w_eq[0])
  );

  always_comb begin
    w_match = &w_eq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match;
    end
  end

  assign match = r_match;

`ifdef VERIFIER_MISMATCH_FLAGS_EN
  logic [N_FIELD-1:0] r_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch <= '0;
    end else begin
      r_mismatch <= ~w_eq;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule : verifier_top

// File: tb/tb_verifier_top.sv
// Scoreboard bench for verifier_top: driver pushes model results, monitor pops and compares.
// Also checks mismatch[3:0] and its invariant when VERIFIER_MISMATCH_FLAGS_EN is defined.
module tb_verifier_top;

  localparam logic [31:0] GOLDEN = 32'h0A0110F3;

  logic        clk;
  logic        rst;
  logic [31:0] signature_in;
  logic        match;
`ifdef VERIFIER_MISMATCH_FLAGS_EN
  logic [3:0]  mismatch;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [4:0]  exp_q[$];
  logic        done = 1'b0;

  verifier_top dut (
    .clk          (clk),
    .rst          (rst),
    .signature_in (signature_in),
    .match        (match)
`ifdef VERIFIER_MISMATCH_FLAGS_EN
    ,
    .mismatch     (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word identity against the golden word; per-byte flags for mismatch.
  function automatic logic [4:0] model(input logic r, input logic [31:0] w);
    logic [31:0] g;
    logic [3:0]  mm;
    g = GOLDEN;
    if (r) return 5'b0;
    for (int k = 0; k < 4; k++) mm[k] = (w[8*k +: 8] != g[8*k +: 8]);
    return {mm, (w == g)};
  endfunction

  // Inputs are applied away from posedge; the result appears after the next posedge.
  task automatic drive(input logic r, input logic [31:0] w);
    rst          = r;
    signature_in = w;
    exp_q.push_back(model(r, w));
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (match !== e[0]) begin
          failures++;
          $display("FAIL match t=%0t in=%h got=%b want=%b", $time, dut.signature_in, match, e[0]);
        end
`ifdef VERIFIER_MISMATCH_FLAGS_EN
        checks++;
        if (mismatch !== e[4:1]) begin
          failures++;
          $display("FAIL mismatch t=%0t got=%b want=%b", $time, mismatch, e[4:1]);
        end
        checks++;
        if (match !== (mismatch == 4'b0000)) begin
          failures++;
          $display("FAIL invariant t=%0t match=%b mismatch=%b", $time, match, mismatch);
        end
`endif
      end else if (!done) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow t=%0t got=empty want=entry", $time);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] w;
    logic [7:0]  b;
    int unsigned fld;
    int unsigned budget;

    // Reset held for two edges with the golden word present.
    drive(1'b1, GOLDEN);
    drive(1'b1, GOLDEN);

    // Directed single-field faults, including +/-1 around the expiry code.
    drive(1'b0, 32'h0A0110F3);
    drive(1'b0, 32'h0B0110F3);
    drive(1'b0, 32'h0A0210F3);
    drive(1'b0, 32'h0A0110AA);
    drive(1'b0, 32'h0A0111F3);
    drive(1'b0, 32'h0A010FF3);
    drive(1'b0, 32'hFFFFFFFF);
    drive(1'b0, 32'h00000000);

    // Back-to-back alternation: result must toggle every cycle.
    for (int i = 0; i < 8; i++) drive(1'b0, (i % 2 == 0) ? 32'h0A0110F3 : 32'h0A0111F3);

    // Reset during a valid word, then recovery with no stale result.
    drive(1'b0, GOLDEN);
    drive(1'b1, GOLDEN);
    drive(1'b0, GOLDEN);
    drive(1'b0, 32'h0A0111F3);

    // Random mix: near-golden words with one field perturbed, fully random words, rare resets.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: w = GOLDEN;
        1: w = $urandom;
        default: begin
          w   = GOLDEN;
          fld = $urandom_range(0, 3);
          b   = 8'($urandom_range(1, 255));
          w[8*fld +: 8] = w[8*fld +: 8] ^ b;
        end
      endcase
      drive(($urandom_range(0, 19) == 0), w);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    done = 1'b1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0 entries left", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_verifier_top
